snake_head_mover: RTL and testbench
===================================

Name: snake_head_mover

Overview:
- Consumes the 2-bit direction code from the button encoder and advances the snake head one grid cell every TICK_DIV enabled clocks.
- Blocks 180-degree reversals, handles grid edges and exposes head position, committed direction and a move strobe.
- Feeds the body/collision logic and the renderer.

Parameters:
- GRID_W, 32, grid width in cells.
- GRID_H, 24, grid height in cells.
- X_W, 5, head_x width; must satisfy 2^X_W >= GRID_W.
- Y_W, 5, head_y width; must satisfy 2^Y_W >= GRID_H.
- TICK_DIV, 4, enabled clocks per move; must be >= 2.
- START_X, 16, head x after reset.
- START_Y, 12, head y after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- enable  in  1  1 = run, 0 = pause.
- dir_in  in  2  direction code: 01 up, 10 down, 11 left, 00 right.
- head_x  out  X_W  head column.
- head_y  out  Y_W  head row.
- cur_dir  out  2  committed direction, same encoding as dir_in.
- step  out  1  one-cycle pulse on the cycle the head moved.
- dead  out  1  head hit a wall; sticky until reset.

Behaviour:
- Reset (reset=0, immediate, independent of clk):
  - state=IDLE; head_x=START_X; head_y=START_Y.
  - cur_dir=00; pending=00; tick_cnt=0; step=0; dead=0.
- States: IDLE, RUN, DEAD. All outputs are registered.
- IDLE:
  - enable=1 -> RUN on the next edge; tick_cnt=0.
  - No moves; step=0.
- RUN:
  - enable=1: tick_cnt increments each clock.
  - When tick_cnt==TICK_DIV-1: tick_cnt wraps to 0 and a move fires on that edge.
  - enable=0: tick_cnt holds and no move occurs; state stays RUN.
  - First move fires TICK_DIV enabled clocks after entering RUN.
- Direction capture:
  - dir_in is sampled every clock in IDLE and RUN.
  - ref = pending if a move fires this edge, else cur_dir.
  - Reverse test: (dir_in ^ ref)==2'b11. A reverse is ignored; any other value is written to pending.
  - This rule prevents a reversal when dir_in changes on the same edge as a move.
- Move edge:
  - cur_dir<=pending.
  - Head steps by pending: up y-1, down y+1, left x-1, right x+1.
  - step=1 for exactly that cycle; step is 0 on all other cycles.
  - head_x, head_y, cur_dir and step update on the same edge (zero added latency).
- Edge handling, per Optional Feature:
  - Leaving the grid means x<0, x>GRID_W-1, y<0 or y>GRID_H-1.
  - Wrap mode: arithmetic is modulo GRID_W / GRID_H, not modulo 2^X_W / 2^Y_W.
  - Wall mode: the head does not move, cur_dir is still committed, step=0, dead<=1, state->DEAD.
- DEAD:
  - All outputs frozen; dir_in and enable are ignored.
  - Exit only by reset.
- Reset mid-move or mid-pause: immediate return to the reset values; no partial update.

Optional Feature:
- Macro: SNAKE_WALL_WRAP_EN.
- Defined: edges wrap, e.g. x=GRID_W-1 moving right -> x=0; y=0 moving up -> y=GRID_H-1. dead is tied to 0 and DEAD is unreachable.
- Undefined: wall mode as described in Behaviour (dead asserted, state->DEAD).

Test Plan:
- Reset release with enable=1, dir_in=00, TICK_DIV=4 -> step pulses every 4 clocks; head_x steps 16->17->18 with head_y=12.
- cur_dir=00, dir_in=11 held for 3 moves -> pending unchanged, no reversal, head_x keeps incrementing. Then dir_in=01 -> next move gives head_y=11 and cur_dir=01.
- Same-edge race: cur_dir=00, pending=01, dir_in=10 on the move edge -> cur_dir=01 and pending stays 01, since 10 is the reverse of ref=01.
- enable=0 for 10 clocks mid-count -> no step, tick_cnt frozen. Re-enable -> move fires after the remaining count, not after a full TICK_DIV.
- Head at x=31 moving right:
  - With SNAKE_WALL_WRAP_EN: head_x=0 and step=1.
  - Without: head_x stays 31, dead=1, step=0, outputs frozen until reset.
- reset=0 asynchronously mid-RUN at head (20,5) -> outputs return to (16,12), cur_dir=00, step=0 and dead=0 before the next clk edge.

Source files
------------

// File: rtl/snake_head_mover.sv
// snake_head_mover: advances the snake head one cell every TICK_DIV enabled clocks and ignores reversal requests.
// Macro SNAKE_WALL_WRAP_EN: when defined, the head wraps at grid edges; otherwise hitting a wall is fatal.
module snake_head_mover #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int TICK_DIV = 4,
    parameter int START_X  = 16,
    parameter int START_Y  = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [1:0]     dir_in,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [1:0]     cur_dir,
    output logic           step,
    output logic           dead
);
    localparam int T_W = $clog2(TICK_DIV);
    localparam logic [T_W-1:0] T_MAX = T_W'(TICK_DIV - 1);
    localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [1:0] D_UP = 2'b01, D_DN = 2'b10, D_LT = 2'b11, D_RT = 2'b00;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t         state_q, state_d;
    logic [T_W-1:0] tick_q, tick_d;
    logic [X_W-1:0] x_q, x_d, nx;
    logic [Y_W-1:0] y_q, y_d, ny;
    logic [1:0]     cur_dir_q, cur_dir_d, pending_q, pending_d, ref_dir;
    logic           step_q, step_d, dead_q, dead_d, fire;
`ifndef SNAKE_WALL_WRAP_EN
    logic           hit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            cur_dir_q <= D_RT;
            pending_q <= D_RT;
            step_q    <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cur_dir_q <= cur_dir_d;
            pending_q <= pending_d;
            step_q    <= step_d;
            dead_q    <= dead_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        x_d       = x_q;
        y_d       = y_q;
        cur_dir_d = cur_dir_q;
        pending_d = pending_q;
        step_d    = 1'b0;
        dead_d    = dead_q;
        fire      = state_q == RUN && enable && tick_q == T_MAX;
        // Compare against the direction that will be current after this edge
        ref_dir   = fire ? pending_q : cur_dir_q;
        nx = pending_q == D_LT ? (x_q == '0 ? X_MAX : x_q - 1'b1) :
             pending_q == D_RT ? (x_q == X_MAX ? '0 : x_q + 1'b1) : x_q;
        ny = pending_q == D_UP ? (y_q == '0 ? Y_MAX : y_q - 1'b1) :
             pending_q == D_DN ? (y_q == Y_MAX ? '0 : y_q + 1'b1) : y_q;
        if (state_q != DEAD && (dir_in ^ ref_dir) != 2'b11)
            pending_d = dir_in;
        if (state_q == IDLE && enable) begin
            state_d = RUN;
            tick_d  = '0;
        end
        if (state_q == RUN && enable)
            tick_d = fire ? '0 : tick_q + 1'b1;
`ifdef SNAKE_WALL_WRAP_EN
        if (fire) begin
            cur_dir_d = pending_q;
            x_d       = nx;
            y_d       = ny;
            step_d    = 1'b1;
        end
`else
        hit = (pending_q == D_UP && y_q == '0) || (pending_q == D_DN && y_q == Y_MAX) ||
              (pending_q == D_LT && x_q == '0) || (pending_q == D_RT && x_q == X_MAX);
        if (fire) begin
            cur_dir_d = pending_q;
            if (hit) begin
                dead_d  = 1'b1;
                state_d = DEAD;
            end else begin
                x_d    = nx;
                y_d    = ny;
                step_d = 1'b1;
            end
        end
`endif
    end

    assign head_x  = x_q;
    assign head_y  = y_q;
    assign cur_dir = cur_dir_q;
    assign step    = step_q;
    assign dead    = dead_q;
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed checks of movement, reversal guard, pause, edge handling and async reset.
module tb_snake_head_mover;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [4:0] head_x, head_y;
    logic [1:0] cur_dir;
    logic       step, dead;
    int         checks = 0;
    int         failures = 0;
    int         sc;

    snake_head_mover dut (
        .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in),
        .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir), .step(step), .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clkn(input int n);
        repeat (n) clk1();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        clkn(2);
        chk("rst_x", head_x, 16);
        chk("rst_y", head_y, 12);
        chk("rst_dir", cur_dir, 0);
        chk("rst_step", step, 0);
        chk("rst_dead", dead, 0);
        // first move fires on the 5th edge: 1 edge to enter RUN + TICK_DIV counts
        reset = 1'b1; enable = 1'b1; dir_in = 2'b00;
        clkn(4);
        chk("pre_move_step", step, 0);
        chk("pre_move_x", head_x, 16);
        clk1();
        chk("move1_step", step, 1);
        chk("move1_x", head_x, 17);
        clkn(3);
        chk("between_step", step, 0);
        chk("between_x", head_x, 17);
        clk1();
        chk("move2_step", step, 1);
        chk("move2_x", head_x, 18);
        chk("move2_y", head_y, 12);
        // reverse request (left while moving right) is ignored for 3 moves
        dir_in = 2'b11;
        clkn(12);
        chk("rev_x", head_x, 21);
        chk("rev_dir", cur_dir, 0);
        chk("rev_step", step, 1);
        dir_in = 2'b01;
        clkn(4);
        chk("up_y", head_y, 11);
        chk("up_x", head_x, 21);
        chk("up_dir", cur_dir, 1);
        dir_in = 2'b00;
        clkn(4);
        chk("right_x", head_x, 22);
        chk("right_dir", cur_dir, 0);
        // same-edge race: pending=up, down arrives on the move edge
        dir_in = 2'b01;
        clkn(3);
        dir_in = 2'b10;
        clk1();
        chk("race_dir", cur_dir, 1);
        chk("race_y", head_y, 10);
        chk("race_step", step, 1);
        clkn(4);
        chk("race_next_y", head_y, 9);
        chk("race_next_dir", cur_dir, 1);
        // pause mid-count, then resume with the remaining two counts
        dir_in = 2'b01;
        clkn(2);
        enable = 1'b0;
        sc = 0;
        repeat (10) begin
            clk1();
            sc += int'(step);
        end
        chk("pause_steps", sc, 0);
        chk("pause_y", head_y, 9);
        enable = 1'b1;
        clk1();
        chk("resume1_step", step, 0);
        chk("resume1_y", head_y, 9);
        clk1();
        chk("resume2_step", step, 1);
        chk("resume2_y", head_y, 8);
        // run right to the last column (22 -> 31)
        dir_in = 2'b00;
        clkn(36);
        chk("edge_x", head_x, 31);
        chk("edge_dir", cur_dir, 0);
        clkn(4);
`ifdef SNAKE_WALL_WRAP_EN
        chk("wrap_x", head_x, 0);
        chk("wrap_step", step, 1);
        chk("wrap_dead", dead, 0);
        clkn(4);
        chk("wrap_next_x", head_x, 1);
`else
        chk("wall_x", head_x, 31);
        chk("wall_step", step, 0);
        chk("wall_dead", dead, 1);
        chk("wall_dir", cur_dir, 0);
        dir_in = 2'b01;
        sc = 0;
        repeat (8) begin
            clk1();
            sc += int'(step);
        end
        chk("dead_steps", sc, 0);
        chk("dead_x", head_x, 31);
        chk("dead_y", head_y, 8);
        chk("dead_dir", cur_dir, 0);
        chk("dead_hold", dead, 1);
`endif
        // asynchronous reset between edges, right after a move
        reset = 1'b0;
        clk1();
        reset = 1'b1; enable = 1'b1; dir_in = 2'b00;
        clkn(5);
        chk("pre_arst_step", step, 1);
        chk("pre_arst_x", head_x, 17);
        #2 reset = 1'b0;
        #1;
        chk("arst_x", head_x, 16);
        chk("arst_y", head_y, 12);
        chk("arst_dir", cur_dir, 0);
        chk("arst_step", step, 0);
        chk("arst_dead", dead, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
